conv_sched: RTL and testbench
=============================

CONV_SCHED -- requirements
Module: conv_sched

Interface
REQ-001 The module SHALL have parameter TILE_W, default 8: width of tile count and tile index.
REQ-002 The module SHALL have parameter TIMEOUT, default 1024: maximum cycles allowed in any wait state.
REQ-003 The module SHALL use one clock; reset is synchronous and active-high.
REQ-004 The module SHALL have the following ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  request to run a job; sampled in IDLE
- num_tiles  input  TILE_W  number of tiles; latched on start
- done_mem_l1  input  1  layer-1 memory read complete
- done_pe_l1  input  1  layer-1 PE complete
- done_mem_l2  input  1  layer-2 memory read complete
- done_pe_l2  input  1  layer-2 PE complete
- start_mem_l1  output  1  layer-1 memory read enable, held level
- start_pe_l1  output  1  layer-1 PE enable, held level
- wrmem_en_l2  output  1  write layer-1 result into layer-2 memory, 1-cycle pulse
- start_mem_l2  output  1  layer-2 memory read enable, held level
- start_pe_l2  output  1  layer-2 PE enable, held level
- wrmem_en_out  output  1  write layer-2 result to output memory, 1-cycle pulse
- tile_idx  output  TILE_W  index of the current tile, 0-based
- busy  output  1  job in progress
- done  output  1  job complete, 1-cycle pulse
- err  output  1  watchdog timeout, sticky

Function
REQ-005 The FSM SHALL have the states IDLE, LATCH, RD_L1, PE_L1, WB_L1, RD_L2, PE_L2, WB_L2, NEXT, DONE and ERR, with registered state and Moore outputs.
REQ-006 In IDLE, start=1 SHALL cause a transition to LATCH; num_tiles SHALL be captured into an internal register and tile_idx SHALL be cleared to 0.
REQ-007 LATCH SHALL go to DONE if the captured count is 0; otherwise it SHALL go to RD_L1.
REQ-008 Each wait state SHALL hold its enable at 1 and advance on its done input: RD_L1->PE_L1 on done_mem_l1, PE_L1->WB_L1 on done_pe_l1, RD_L2->PE_L2 on done_mem_l2, PE_L2->WB_L2 on done_pe_l2.
REQ-009 The done input SHALL be sampled on the same edge that leaves the state, so the enable drops on the cycle after done is seen.
REQ-010 WB_L1 SHALL assert wrmem_en_l2 for exactly one cycle and then go to RD_L2.
REQ-011 WB_L2 SHALL assert wrmem_en_out for exactly one cycle and then go to NEXT.
REQ-012 NEXT SHALL go to DONE if tile_idx == captured count-1; otherwise it SHALL increment tile_idx by 1 and go to RD_L1.
REQ-013 DONE SHALL assert done for one cycle and return to IDLE; tile_idx SHALL hold its final value until the next LATCH.
REQ-014 busy SHALL be 1 in every state except IDLE and ERR.
REQ-015 start SHALL be ignored outside IDLE, and num_tiles changes SHALL be ignored after LATCH.
REQ-016 A done input arriving in a state other than its own wait state SHALL be ignored.
REQ-017 Watchdog: a cycle counter SHALL clear on entry to each wait state and increment each cycle spent in it.
REQ-018 When the watchdog counter reaches TIMEOUT-1 with no done, the FSM SHALL go to ERR on the next edge.
REQ-019 ERR SHALL set err=1 and drive all enables and pulses to 0; ERR SHALL be exited only by rst.
REQ-020 With a tile count of 2^TILE_W-1, tiles SHALL be processed without wrap-around of tile_idx.

Reset
REQ-021 rst=1 at any edge, including mid-job, SHALL force IDLE with every output 0, tile_idx=0, the watchdog counter at 0 and err=0.
REQ-022 rst SHALL override start and all done inputs on the same edge.

Verification
REQ-023 num_tiles=2, each done returned 3 cycles after its enable -> RD_L1..WB_L2 sequence runs twice; exactly two wrmem_en_l2 and two wrmem_en_out pulses; tile_idx goes 0 then 1; one done pulse.
REQ-024 num_tiles=0, start pulse -> IDLE, LATCH, DONE, IDLE; no enable ever asserted; done=1 for one cycle.
REQ-025 done_pe_l2 forced high during RD_L1, start re-pulsed while busy -> both ignored; sequence and tile_idx unchanged.
REQ-026 TIMEOUT=16, done_mem_l2 never returned -> ERR entered 16 cycles after entering RD_L2; err=1 and start_mem_l2=0 until rst.
REQ-027 rst asserted during PE_L1 of tile 1 -> next cycle IDLE with all outputs 0; a fresh start then runs normally from tile_idx=0.
REQ-028 done_mem_l1 arrives on the first cycle of RD_L1 -> start_mem_l1 high for exactly 1 cycle; PE_L1 entered on the next edge.

Source files
------------

// File: rtl/conv_sched.sv
// conv_sched: two-layer convolution tile scheduler
// with a per-wait-state watchdog.
module conv_sched #(
  parameter int TILE_W  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [TILE_W-1:0] num_tiles,
  input  logic              done_mem_l1,
  input  logic              done_pe_l1,
  input  logic              done_mem_l2,
  input  logic              done_pe_l2,
  output logic              start_mem_l1,
  output logic              start_pe_l1,
  output logic              wrmem_en_l2,
  output logic              start_mem_l2,
  output logic              start_pe_l2,
  output logic              wrmem_en_out,
  output logic [TILE_W-1:0] tile_idx,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, LATCH, RD_L1, PE_L1, WB_L1,
    RD_L2, PE_L2, WB_L2, NEXT, DONE, ERR
  } state_t;

  state_t            state;
  state_t            nxt;
  logic [TILE_W-1:0] cnt;
  logic [WD_W-1:0]   wd;
  logic              wait_st;
  logic              wd_exp;
  logic              last;

  assign wait_st = state inside {RD_L1, PE_L1, RD_L2, PE_L2};
  assign wd_exp  = wd == WD_W'(TIMEOUT - 1);
  assign last    = tile_idx == cnt - TILE_W'(1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (start) nxt = LATCH;
      LATCH: nxt = (cnt == '0) ? DONE : RD_L1;
      RD_L1: begin
        if (done_mem_l1) nxt = PE_L1;
        else if (wd_exp) nxt = ERR;
      end
      PE_L1: begin
        if (done_pe_l1)  nxt = WB_L1;
        else if (wd_exp) nxt = ERR;
      end
      WB_L1: nxt = RD_L2;
      RD_L2: begin
        if (done_mem_l2) nxt = PE_L2;
        else if (wd_exp) nxt = ERR;
      end
      PE_L2: begin
        if (done_pe_l2)  nxt = WB_L2;
        else if (wd_exp) nxt = ERR;
      end
      WB_L2: nxt = NEXT;
      NEXT:  nxt = last ? DONE : RD_L1;
      DONE:  nxt = IDLE;
      ERR:   nxt = ERR;
      default: nxt = IDLE;
    endcase
  end

  // count and index registers, watchdog restarts on every state change
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      tile_idx <= '0;
      wd       <= '0;
    end else begin
      if (state == IDLE && start) begin
        cnt      <= num_tiles;
        tile_idx <= '0;
      end
      if (state == NEXT && !last)
        tile_idx <= tile_idx + TILE_W'(1);
      if (nxt != state) wd <= '0;
      else if (wait_st) wd <= wd + WD_W'(1);
    end
  end

  always_comb begin
    start_mem_l1 = 1'b0;
    start_pe_l1  = 1'b0;
    wrmem_en_l2  = 1'b0;
    start_mem_l2 = 1'b0;
    start_pe_l2  = 1'b0;
    wrmem_en_out = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    busy         = 1'b1;
    unique case (state)
      IDLE:  busy = 1'b0;
      RD_L1: start_mem_l1 = 1'b1;
      PE_L1: start_pe_l1  = 1'b1;
      WB_L1: wrmem_en_l2  = 1'b1;
      RD_L2: start_mem_l2 = 1'b1;
      PE_L2: start_pe_l2  = 1'b1;
      WB_L2: wrmem_en_out = 1'b1;
      DONE:  done = 1'b1;
      ERR: begin
        busy = 1'b0;
        err  = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_conv_sched.sv
// tb_conv_sched: randomized scoreboard bench for conv_sched
// with a responder that returns done after planned delays.
module tb_conv_sched;
  localparam int TW = 8;
  localparam int TO = 16;
  localparam int K_WB1  = 0;
  localparam int K_WB2  = 1;
  localparam int K_DONE = 2;
  localparam int K_ERR  = 3;

  typedef struct {
    int kind;
    int tile;
    int at;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [TW-1:0] num_tiles = '0;
  logic [3:0]    dn = '0;
  logic          start_mem_l1, start_pe_l1, wrmem_en_l2;
  logic          start_mem_l2, start_pe_l2, wrmem_en_out;
  logic [TW-1:0] tile_idx;
  logic          busy, done, err;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_at = 0;
  ev_t  sb[$];
  int   dq[4][$];
  int   dly[4] = '{default: 0};
  int   k[4] = '{default: 0};
  bit   noise = 1'b0;
  logic err_q = 1'b0;

  conv_sched #(.TILE_W(TW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start),
    .num_tiles(num_tiles),
    .done_mem_l1(dn[0]), .done_pe_l1(dn[1]),
    .done_mem_l2(dn[2]), .done_pe_l2(dn[3]),
    .start_mem_l1(start_mem_l1),
    .start_pe_l1(start_pe_l1),
    .wrmem_en_l2(wrmem_en_l2),
    .start_mem_l2(start_mem_l2),
    .start_pe_l2(start_pe_l2),
    .wrmem_en_out(wrmem_en_out),
    .tile_idx(tile_idx), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "bench stalled");
  end

  function automatic logic [8:0] outs();
    return {start_mem_l1, start_pe_l1, wrmem_en_l2,
            start_mem_l2, start_pe_l2, wrmem_en_out,
            busy, done, err};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  function automatic void push(int kind, int tile, int at);
    ev_t e;
    e.kind = kind;
    e.tile = tile;
    e.at   = at;
    sb.push_back(e);
    if (at > last_at) last_at = at;
  endfunction

  task automatic expect_ev(input int kind);
    ev_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event kind=%0d cyc=%0d tile=%0d",
               kind, cyc, tile_idx);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.at != cyc ||
          e.tile != int'(tile_idx) ||
          busy !== (kind != K_ERR)) begin
        fails++;
        $display("FAIL event actual kind=%0d cyc=%0d tile=%0d busy=%0b required kind=%0d cyc=%0d tile=%0d",
                 kind, cyc, tile_idx, busy,
                 e.kind, e.at, e.tile);
      end
    end
  endtask

  // monitor: every pulse or error entry must match the next expected event
  always @(negedge clk) begin
    if (!rst) begin
      if (wrmem_en_l2)  expect_ev(K_WB1);
      if (wrmem_en_out) expect_ev(K_WB2);
      if (done)         expect_ev(K_DONE);
      if (err && !err_q) expect_ev(K_ERR);
    end
    err_q = err;
  end

  // responder: done on the d-th cycle of an enable, d=0 never
  always @(negedge clk) begin : rsp
    logic [3:0] e;
    e = {start_pe_l2, start_mem_l2, start_pe_l1, start_mem_l1};
    for (int c = 0; c < 4; c++) begin
      if (e[c]) begin
        if (k[c] == 0) begin
          tests++;
          if (dq[c].size() == 0) begin
            fails++;
            $display("FAIL unexpected_enable ch=%0d cyc=%0d actual=1 required=0",
                     c, cyc);
            dly[c] = 1;
          end else begin
            dly[c] = dq[c].pop_front();
          end
        end
        k[c]++;
        dn[c] = dly[c] != 0 && k[c] == dly[c];
      end else begin
        k[c]  = 0;
        dn[c] = 1'b0;
      end
    end
    if (noise && start_mem_l1) dn[3] = 1'b1;
  end

  task automatic plan_job(input int n, input int fix);
    int b, t0;
    int d[4];
    t0 = cyc + 1;
    b  = t0 + 1;
    if (n == 0) push(K_DONE, 0, t0 + 1);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < 4; c++) begin
        d[c] = fix != 0 ? fix : int'($urandom_range(1, 6));
        dq[c].push_back(d[c]);
      end
      push(K_WB1, i, b + d[0] + d[1]);
      b += d[0] + d[1] + 1;
      push(K_WB2, i, b + d[2] + d[3]);
      b += d[2] + d[3] + 2;
    end
    if (n > 0) push(K_DONE, n - 1, b);
  endtask

  task automatic drain(input bit nz);
    int lim;
    lim   = last_at + 20;
    noise = nz;
    while (sb.size() != 0 && cyc <= lim) begin
      @(negedge clk); #1;
      num_tiles = TW'($urandom);
      start = nz && busy && ($urandom_range(0, 2) == 0);
    end
    start = 1'b0;
    noise = 1'b0;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout pending=%0d required=0 cyc=%0d",
               sb.size(), cyc);
      sb.delete();
    end
  endtask

  function automatic int dq_left();
    return dq[0].size() + dq[1].size() +
           dq[2].size() + dq[3].size();
  endfunction

  function automatic void flush();
    sb.delete();
    for (int c = 0; c < 4; c++) dq[c].delete();
  endfunction

  task automatic run_job(input int n, input int fix,
                         input bit nz);
    @(negedge clk); #1;
    chk("pre_idle_busy", busy, 0);
    num_tiles = TW'(n);
    plan_job(n, fix);
    start = 1'b1;
    drain(nz);
    @(negedge clk); #1;
    chk("post_idle_busy", busy, 0);
    chk("final_tile", tile_idx, n == 0 ? 0 : n - 1);
    chk("enables_used", dq_left(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk); #1;
    chk("reset_outs", outs(), 0);
    chk("reset_tile", tile_idx, 0);
    rst = 1'b0;
    flush();
  endtask

  initial begin
    int n, d0, d1, t0;
    repeat (3) @(negedge clk);
    #1;
    do_reset();

    run_job(2, 3, 1'b0);
    run_job(0, 0, 1'b0);
    run_job(3, 0, 1'b1);
    run_job(1, 1, 1'b0);
    for (int j = 0; j < 5; j++)
      run_job(int'($urandom_range(1, 4)), 0, j[0]);

    // reset while tile 1 sits in PE_L1
    @(negedge clk); #1;
    num_tiles = TW'(3);
    plan_job(3, 0);
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(start_pe_l1 && tile_idx == 1) && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    chk("reach_pe_l1_tile1", n < 200, 1);
    do_reset();
    run_job(2, 0, 1'b0);

    run_job(255, 1, 1'b0);

    // watchdog: layer-2 memory never answers
    @(negedge clk); #1;
    num_tiles = TW'(1);
    t0 = cyc + 1;
    d0 = int'($urandom_range(1, 6));
    d1 = int'($urandom_range(1, 6));
    dq[0].push_back(d0);
    dq[1].push_back(d1);
    dq[2].push_back(0);
    push(K_WB1, 0, t0 + 1 + d0 + d1);
    push(K_ERR, 0, t0 + 2 + d0 + d1 + TO);
    start = 1'b1;
    drain(1'b0);
    for (int j = 0; j < 4; j++) begin
      start = j[0];
      @(negedge clk); #1;
      chk("err_sticky", err, 1);
      chk("err_mem_l2", start_mem_l2, 0);
      chk("err_busy", busy, 0);
    end
    start = 1'b0;
    do_reset();
    run_job(2, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
